// File: rtl/control_bus_rtc.sv
`timescale 1ns/1ps
// control_bus_rtc: sequences one address/data bus cycle on a multiplexed RTC bus.
// Optional macro CTRL_BUS_TURNAROUND_EN adds a one-cycle bus turnaround between address and data phases.
module control_bus_rtc #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       leer,
    input  logic [7:0] direccion,
    input  logic [7:0] dato_escritura,
    output logic [7:0] dato_leido,
    output logic       listo,
    output logic       ocupado,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    input  logic [7:0] ad_in
);

    if (T_SETUP < 1 || T_SETUP > 15 || T_PULSE < 1 || T_PULSE > 15 ||
        T_HOLD < 1 || T_HOLD > 15) begin : g_param_check
        $error("control_bus_rtc: T_SETUP, T_PULSE and T_HOLD must be in 1..15");
    end

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_PULSE, A_HOLD, TURN, D_SETUP, D_PULSE, D_HOLD, FIN
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] last;
    logic       phase_done;

    logic       cap_leer;
    logic [7:0] cap_dir;
    logic [7:0] cap_dato;

    logic       rd_sel;
    logic [7:0] dir_sel;
    logic [7:0] dato_sel;
    logic       addr_ph;
    logic       data_ph;

    always_comb begin
        last = 4'd0;
        case (state)
            A_SETUP, D_SETUP: last = 4'(T_SETUP - 1);
            A_PULSE, D_PULSE: last = 4'(T_PULSE - 1);
            A_HOLD,  D_HOLD:  last = 4'(T_HOLD - 1);
            default:          last = 4'd0;
        endcase
    end

    assign phase_done = (cnt == last);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iniciar)    state_nxt = A_SETUP;
            A_SETUP: if (phase_done) state_nxt = A_PULSE;
            A_PULSE: if (phase_done) state_nxt = A_HOLD;
`ifdef CTRL_BUS_TURNAROUND_EN
            A_HOLD:  if (phase_done) state_nxt = TURN;
`else
            A_HOLD:  if (phase_done) state_nxt = D_SETUP;
`endif
            TURN:                    state_nxt = D_SETUP;
            D_SETUP: if (phase_done) state_nxt = D_PULSE;
            D_PULSE: if (phase_done) state_nxt = D_HOLD;
            D_HOLD:  if (phase_done) state_nxt = FIN;
            FIN:                     state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so the request fields come
    // straight from the inputs on the accepting edge and from the capture afterwards.
    assign rd_sel   = (state == IDLE) ? leer           : cap_leer;
    assign dir_sel  = (state == IDLE) ? direccion      : cap_dir;
    assign dato_sel = (state == IDLE) ? dato_escritura : cap_dato;
    assign addr_ph  = state_nxt inside {A_SETUP, A_PULSE, A_HOLD};
    assign data_ph  = state_nxt inside {D_SETUP, D_PULSE, D_HOLD};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_leer   <= 1'b0;
            cap_dir    <= 8'h00;
            cap_dato   <= 8'h00;
            dato_leido <= 8'h00;
            listo      <= 1'b0;
            ocupado    <= 1'b0;
            cs_n       <= 1'b1;
            ad_n       <= 1'b1;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            ad_out     <= 8'h00;
            ad_oe      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt == state && state != IDLE) ? cnt + 4'd1 : 4'd0;

            if (state == IDLE && iniciar) begin
                cap_leer <= leer;
                cap_dir  <= direccion;
                cap_dato <= dato_escritura;
            end

            if (state == D_PULSE && phase_done && cap_leer) begin
                dato_leido <= ad_in;
            end

            cs_n    <= (state_nxt == IDLE) || (state_nxt == FIN);
            ad_n    <= !addr_ph;
            wr_n    <= !((state_nxt == A_PULSE) || (state_nxt == D_PULSE && !rd_sel));
            rd_n    <= !(state_nxt == D_PULSE && rd_sel);
            ad_oe   <= addr_ph || (data_ph && !rd_sel);
            ad_out  <= addr_ph ? dir_sel : ((data_ph && !rd_sel) ? dato_sel : 8'h00);
            listo   <= (state_nxt == FIN);
            ocupado <= !(state_nxt == IDLE || state_nxt == FIN);
        end
    end

endmodule

// File: tb/tb_control_bus_rtc.sv
`timescale 1ns/1ps
// tb_control_bus_rtc: directed bus-cycle timing checks for control_bus_rtc,
// default timing plus a minimum-timing instance.
module tb_control_bus_rtc;

`ifdef CTRL_BUS_TURNAROUND_EN
    localparam int TA = 1;
`else
    localparam int TA = 0;
`endif
    localparam int PER = 18 + TA;
    localparam logic [7:0] IDLE_CTRL = 8'b0111_1000;

    logic       clk = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       iniciar_m;
    logic       leer;
    logic [7:0] direccion;
    logic [7:0] dato_escritura;
    logic [7:0] ad_in;

    logic [7:0] dato_leido, ad_out;
    logic       listo, ocupado, cs_n, ad_n, rd_n, wr_n, ad_oe;
    logic [7:0] dato_leido_m, ad_out_m;
    logic       listo_m, ocupado_m, cs_n_m, ad_n_m, rd_n_m, wr_n_m, ad_oe_m;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_bus_rtc dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .leer(leer),
        .direccion(direccion), .dato_escritura(dato_escritura),
        .dato_leido(dato_leido), .listo(listo), .ocupado(ocupado),
        .cs_n(cs_n), .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in)
    );

    control_bus_rtc #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_m (
        .clk(clk), .reset(reset), .iniciar(iniciar_m), .leer(leer),
        .direccion(direccion), .dato_escritura(dato_escritura),
        .dato_leido(dato_leido_m), .listo(listo_m), .ocupado(ocupado_m),
        .cs_n(cs_n_m), .ad_n(ad_n_m), .rd_n(rd_n_m), .wr_n(wr_n_m),
        .ad_out(ad_out_m), .ad_oe(ad_oe_m), .ad_in(ad_in)
    );

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Expected {0, cs_n, ad_n, rd_n, wr_n, ad_oe, listo, ocupado} for cycle n of a
    // default-timing transfer accepted at edge 0.
    function automatic logic [7:0] expCtrl(input int n, input logic rd);
        logic cs, ad, r, w, oe, ls, oc;
        cs = 1; ad = 1; r = 1; w = 1; oe = 0; ls = 0; oc = 0;
        if (n >= 1 && n <= 16 + TA) begin cs = 0; oc = 1; end
        if (n >= 1 && n <= 8) begin ad = 0; oe = 1; end
        if (n >= 3 && n <= 6) w = 0;
        if (n >= 9 + TA && n <= 16 + TA) oe = !rd;
        if (n >= 11 + TA && n <= 14 + TA) begin
            if (rd) r = 0;
            else    w = 0;
        end
        if (n == 17 + TA) ls = 1;
        return {1'b0, cs, ad, r, w, oe, ls, oc};
    endfunction

    task automatic checkCycle(input string name, input int n, input int m, input logic rd,
                              input logic [7:0] addr, input logic [7:0] data,
                              input logic [7:0] dl_exp);
        checkOutput($sformatf("%s c%0d ctrl", name, n),
                    {1'b0, cs_n, ad_n, rd_n, wr_n, ad_oe, listo, ocupado}, expCtrl(m, rd));
        if (m >= 1 && m <= 8)
            checkOutput($sformatf("%s c%0d ad_out", name, n), ad_out, addr);
        else if (m >= 9 + TA && m <= 16 + TA)
            checkOutput($sformatf("%s c%0d ad_out", name, n), ad_out, rd ? 8'h00 : data);
        checkOutput($sformatf("%s c%0d dato_leido", name, n), dato_leido, dl_exp);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " ctrl"},
                    {1'b0, cs_n, ad_n, rd_n, wr_n, ad_oe, listo, ocupado}, IDLE_CTRL);
        checkOutput({name, " ad_out"}, ad_out, 8'h00);
    endtask

    // One full default-timing transfer; request inputs are scrambled after acceptance.
    task automatic applyStimulus(input string name, input logic rd, input logic [7:0] addr,
                                 input logic [7:0] data, input logic [7:0] dl_old);
        @(negedge clk);
        leer = rd; direccion = addr; dato_escritura = data; iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0; leer = !rd; direccion = ~addr; dato_escritura = ~data;
        for (int n = 1; n <= 20; n++) begin
            ad_in = (n >= 11 + TA && n <= 14 + TA) ? 8'h59 : 8'hA5;
            checkCycle(name, n, n, rd, addr, data,
                       (rd && n >= 15 + TA) ? 8'h59 : dl_old);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int gap;
        reset = 1'b1; iniciar = 1'b0; iniciar_m = 1'b0; leer = 1'b0;
        direccion = 8'h00; dato_escritura = 8'h00; ad_in = 8'h00;
        #1;
        checkIdle("reset");
        checkOutput("reset dato_leido", dato_leido, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 20; n++) begin
            direccion = 8'(n * 13);
            @(negedge clk);
            checkIdle($sformatf("idle%0d", n));
        end

        applyStimulus("wr21", 1'b0, 8'h21, 8'h45, 8'h00);
        applyStimulus("rd22", 1'b1, 8'h22, 8'h77, 8'h00);
        applyStimulus("wr10", 1'b0, 8'h10, 8'h20, 8'h59);

        // Back-to-back: iniciar held high, inputs change after the first acceptance.
        @(negedge clk);
        leer = 1'b0; direccion = 8'h31; dato_escritura = 8'h41; iniciar = 1'b1;
        @(posedge clk); #1;
        direccion = 8'h32; dato_escritura = 8'h42;
        for (int n = 1; n <= 3 * PER; n++) begin
            int m;
            int k;
            if (n == 40) iniciar = 1'b0;
            m = n;
            while (m > PER) m -= PER;
            k = (n - 1) / PER;
            checkCycle("b2b", n, m, 1'b0, (k == 0) ? 8'h31 : 8'h32,
                       (k == 0) ? 8'h41 : 8'h42, 8'h59);
            @(posedge clk); #1;
        end

        // Reset during the data strobe of a write.
        @(negedge clk);
        leer = 1'b0; direccion = 8'h21; dato_escritura = 8'h45; iniciar = 1'b1;
        @(posedge clk); #1;
        iniciar = 1'b0;
        repeat (11) @(posedge clk);
        #3;
        checkOutput("abort pre wr_n", {7'b0, wr_n}, 8'h00);
        reset = 1'b1;
        #1;
        checkIdle("abort");
        checkOutput("abort dato_leido", dato_leido, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            checkIdle($sformatf("post_abort%0d", n));
        end
        applyStimulus("wr_after", 1'b0, 8'h21, 8'h45, 8'h00);

        // Minimum timing read on the second instance.
        @(negedge clk);
        leer = 1'b1; direccion = 8'h5A; ad_in = 8'h3C; iniciar_m = 1'b1;
        @(posedge clk); #1;
        iniciar_m = 1'b0; leer = 1'b0; direccion = 8'h00;
        gap = 0;
        for (int n = 1; n <= 10; n++) begin
            checkOutput($sformatf("min c%0d listo", n), {7'b0, listo_m}, {7'b0, n == 7 + TA});
            checkOutput($sformatf("min c%0d rd_n", n), {7'b0, rd_n_m}, {7'b0, n != 5 + TA});
            checkOutput($sformatf("min c%0d ocupado", n), {7'b0, ocupado_m},
                        {7'b0, n >= 1 && n <= 6 + TA});
            if (n <= 3)
                checkOutput($sformatf("min c%0d ad_out", n), ad_out_m, 8'h5A);
            if (n == 7 + TA)
                checkOutput("min dato_leido", dato_leido_m, 8'h3C);
            if (n < 5 + TA && !cs_n_m && !ad_oe_m && ad_n_m && rd_n_m && wr_n_m)
                gap++;
            @(posedge clk); #1;
        end
        checkOutput("min gap cycles", 8'(gap), 8'(1 + TA));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
